// File: rtl/obi_arb_pkg.sv
// Shared types for the two-master OBI data-port arbiter: master IDs and
// the arbitration mode encoding.
package obi_arb_pkg;

  typedef logic [0:0] master_id_t;

  localparam master_id_t MID_CORE = 1'b0;
  localparam master_id_t MID_DBG  = 1'b1;

  typedef enum logic {
    PRIO_RR        = 1'b0,
    PRIO_DBG_FIXED = 1'b1
  } prio_mode_e;

  // The other master of the pair; used for the round-robin hand-off.
  function automatic master_id_t other_master(input master_id_t mid);
    return ~mid;
  endfunction

endpackage

// File: rtl/obi_arb_id_fifo.sv
// Small in-order FIFO that remembers which master owns each granted,
// not-yet-answered transaction.
module obi_arb_id_fifo
  import obi_arb_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  master_id_t    push_id_i,
  input  logic          pop_i,
  output master_id_t    head_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  master_id_t    mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    if (ptr == PW'(DEPTH - 1)) begin
      return '0;
    end
    return ptr + PW'(1);
  endfunction

  assign full_o  = (count_reg == CW'(DEPTH));
  assign empty_o = (count_reg == '0);
  assign count_o = count_reg;
  assign head_o  = mem[rd_ptr_reg];

  // Full/empty guards keep the pointers consistent even if a caller misbehaves.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_id_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      if (do_pop) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/obi_data_arbiter.sv
// Two-master OBI arbiter in front of a single in-order slave port; grants
// pass straight through and responses are steered by the ID FIFO head.
module obi_data_arbiter
  import obi_arb_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter int PRIO_MODE       = 0,
  localparam int BE_W           = DATA_WIDTH / 8,
  localparam int CNTW           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [1:0]                 m_req_i,
  input  logic [1:0]                 m_we_i,
  input  logic [1:0][BE_W-1:0]       m_be_i,
  input  logic [1:0][ADDR_WIDTH-1:0] m_addr_i,
  input  logic [1:0][DATA_WIDTH-1:0] m_wdata_i,
  output logic [1:0]                 m_gnt_o,
  output logic [1:0]                 m_rvalid_o,
  output logic [DATA_WIDTH-1:0]      m_rdata_o,
  output logic                       s_req_o,
  output logic                       s_we_o,
  output logic [BE_W-1:0]            s_be_o,
  output logic [ADDR_WIDTH-1:0]      s_addr_o,
  output logic [DATA_WIDTH-1:0]      s_wdata_o,
  input  logic                       s_gnt_i,
  input  logic                       s_rvalid_i,
  input  logic [DATA_WIDTH-1:0]      s_rdata_i,
  output logic [CNTW-1:0]            outstanding_o,
  output logic                       proto_err_o
);

  localparam bit FIXED_PRIO = (PRIO_MODE == int'(PRIO_DBG_FIXED));

  master_id_t sel;
  master_id_t rr_ptr_reg;
  master_id_t fifo_head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       any_req;
  logic       handshake;
  logic       resp_pop;
  logic       proto_err_reg;

  assign any_req = |m_req_i;

  // rr_ptr_reg names the master that wins the next tie.
  always_comb begin
    sel = MID_CORE;
    case (m_req_i)
      2'b01:   sel = MID_CORE;
      2'b10:   sel = MID_DBG;
      2'b11:   sel = FIXED_PRIO ? MID_DBG : rr_ptr_reg;
      default: sel = MID_CORE;
    endcase
  end

  // Registered full flag gates the request, so a pop never frees a slot
  // in the same cycle. Reset is folded in to keep req quiet while held.
  assign s_req_o   = any_req & ~fifo_full & ~rst_i;
  assign handshake = s_req_o & s_gnt_i;
  assign resp_pop  = s_rvalid_i & ~fifo_empty;

  always_comb begin
    s_we_o    = 1'b0;
    s_be_o    = '0;
    s_addr_o  = '0;
    s_wdata_o = '0;
    if (any_req) begin
      s_we_o    = m_we_i[sel];
      s_be_o    = m_be_i[sel];
      s_addr_o  = m_addr_i[sel];
      s_wdata_o = m_wdata_i[sel];
    end
  end

  always_comb begin
    m_gnt_o      = '0;
    m_gnt_o[sel] = handshake;
  end

  always_comb begin
    m_rvalid_o            = '0;
    m_rvalid_o[fifo_head] = resp_pop;
  end

  assign m_rdata_o   = s_rdata_i;
  assign proto_err_o = proto_err_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_reg <= MID_CORE;
    end else if (handshake && !FIXED_PRIO) begin
      rr_ptr_reg <= other_master(sel);
    end
  end

  // A response with nothing outstanding means the slave and arbiter have
  // lost sync (e.g. answers to grants issued before a reset).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      proto_err_reg <= 1'b0;
    end else if (s_rvalid_i && fifo_empty) begin
      proto_err_reg <= 1'b1;
    end
  end

  obi_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_i    (handshake),
    .push_id_i (sel),
    .pop_i     (resp_pop),
    .head_o    (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (outstanding_o)
  );

endmodule

// File: tb/tb_obi_data_arbiter.sv
// Scoreboard bench for obi_data_arbiter: one round-robin instance and one
// fixed-priority instance, responses checked against a queue of grantees.
module tb_obi_data_arbiter;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [1:0]        m_req;
  logic [1:0]        m_we;
  logic [1:0][3:0]   m_be;
  logic [1:0][31:0]  m_addr;
  logic [1:0][31:0]  m_wdata;
  logic              s_gnt;
  logic              s_rvalid;
  logic [31:0]       s_rdata;

  logic [1:0]        m_gnt, m_rvalid;
  logic [31:0]       m_rdata, s_addr, s_wdata;
  logic              s_req, s_we, proto_err;
  logic [3:0]        s_be;
  logic [1:0]        outstanding;

  logic [1:0]        fp_m_req;
  logic              fp_s_gnt, fp_s_rvalid;
  logic [1:0]        fp_m_gnt, fp_m_rvalid;
  logic [31:0]       fp_m_rdata, fp_s_addr, fp_s_wdata;
  logic              fp_s_req, fp_s_we, fp_proto_err;
  logic [3:0]        fp_s_be;
  logic [1:0]        fp_outstanding;

  int checks   = 0;
  int failures = 0;
  int exp_q[$];
  int fp_q[$];

  always #5 clk = ~clk;

  obi_data_arbiter #(.MAX_OUTSTANDING(2), .PRIO_MODE(0)) dut_rr (
    .clk_i(clk), .rst_i(rst),
    .m_req_i(m_req), .m_we_i(m_we), .m_be_i(m_be), .m_addr_i(m_addr), .m_wdata_i(m_wdata),
    .m_gnt_o(m_gnt), .m_rvalid_o(m_rvalid), .m_rdata_o(m_rdata),
    .s_req_o(s_req), .s_we_o(s_we), .s_be_o(s_be), .s_addr_o(s_addr), .s_wdata_o(s_wdata),
    .s_gnt_i(s_gnt), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata),
    .outstanding_o(outstanding), .proto_err_o(proto_err)
  );

  obi_data_arbiter #(.MAX_OUTSTANDING(2), .PRIO_MODE(1)) dut_fp (
    .clk_i(clk), .rst_i(rst),
    .m_req_i(fp_m_req), .m_we_i(m_we), .m_be_i(m_be), .m_addr_i(m_addr), .m_wdata_i(m_wdata),
    .m_gnt_o(fp_m_gnt), .m_rvalid_o(fp_m_rvalid), .m_rdata_o(fp_m_rdata),
    .s_req_o(fp_s_req), .s_we_o(fp_s_we), .s_be_o(fp_s_be), .s_addr_o(fp_s_addr),
    .s_wdata_o(fp_s_wdata),
    .s_gnt_i(fp_s_gnt), .s_rvalid_i(fp_s_rvalid), .s_rdata_i(s_rdata),
    .outstanding_o(fp_outstanding), .proto_err_o(fp_proto_err)
  );

  task automatic idle_inputs();
    m_req = 2'b00; fp_m_req = 2'b00;
    s_gnt = 1'b0; s_rvalid = 1'b0; fp_s_gnt = 1'b0; fp_s_rvalid = 1'b0;
    s_rdata = 32'h0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    idle_inputs();
    exp_q.delete();
    fp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    m_we = 2'b10; m_be = {4'hF, 4'h3};
    m_addr = {32'h1A11_0000, 32'h0000_0100};
    m_wdata = {32'hCAFE_0001, 32'h0};
    @(negedge clk);
    m_req = 2'b11; s_gnt = 1'b1; s_rvalid = 1'b1;
    #1;
    checks++;
    if (s_req !== 1'b0 || m_gnt !== 2'b00 || m_rvalid !== 2'b00) begin
      failures++;
      $display("FAIL reset_outputs: req=%b gnt=%b rvalid=%b, required 0/00/00", s_req, m_gnt, m_rvalid);
    end
    checks++;
    if (outstanding !== 2'd0 || proto_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: outstanding=%0d err=%b, required 0/0", outstanding, proto_err);
    end
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
  endtask

  task automatic test_core_read();
    @(negedge clk);
    m_req = 2'b01; m_we[0] = 1'b0; s_gnt = 1'b1;
    #1;
    checks++;
    if (m_gnt !== 2'b01 || s_addr !== 32'h0000_0100 || s_we !== 1'b0) begin
      failures++;
      $display("FAIL core_grant: gnt=%b addr=%h we=%b, required 01/00000100/0", m_gnt, s_addr, s_we);
    end
    if (s_req && s_gnt) exp_q.push_back(0);
    @(negedge clk);
    m_req = 2'b00; s_gnt = 1'b0;
    #1;
    checks++;
    if (outstanding !== 2'd1) begin
      failures++;
      $display("FAIL core_outst1: got %0d, required 1", outstanding);
    end
    s_rvalid = 1'b1; s_rdata = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (exp_q.size() == 0 || m_rvalid !== (2'b01 << exp_q[0]) || m_rdata !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL core_resp: rvalid=%b rdata=%h, required 01/deadbeef", m_rvalid, m_rdata);
    end
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    @(negedge clk);
    s_rvalid = 1'b0;
    #1;
    checks++;
    if (outstanding !== 2'd0) begin
      failures++;
      $display("FAIL core_outst0: got %0d, required 0", outstanding);
    end
  endtask

  task automatic test_rr_contention();
    logic [1:0] pattern [4];
    int         id;
    pattern[0] = 2'b01; pattern[1] = 2'b10; pattern[2] = 2'b01; pattern[3] = 2'b10;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      m_req = 2'b11; s_gnt = 1'b1;
      s_rvalid = (exp_q.size() != 0);
      s_rdata = 32'h1000_0000 + i;
      #1;
      checks++;
      if (m_gnt !== pattern[i]) begin
        failures++;
        $display("FAIL rr_grant%0d: got %b, required %b", i, m_gnt, pattern[i]);
      end
      if (pattern[i] == 2'b10) begin
        checks++;
        if (s_addr !== 32'h1A11_0000 || s_we !== 1'b1 || s_wdata !== 32'hCAFE_0001) begin
          failures++;
          $display("FAIL rr_dbg_write%0d: addr=%h we=%b wdata=%h, required 1a110000/1/cafe0001",
                   i, s_addr, s_we, s_wdata);
        end
      end
      if (s_rvalid) begin
        id = exp_q.pop_front();
        checks++;
        if (m_rvalid !== (2'b01 << id)) begin
          failures++;
          $display("FAIL rr_resp%0d: got %b, required %b", i, m_rvalid, 2'b01 << id);
        end
      end
      exp_q.push_back(pattern[i] == 2'b10 ? 1 : 0);
    end
    @(negedge clk);
    m_req = 2'b00; s_gnt = 1'b0; s_rvalid = 1'b1;
    #1;
    id = exp_q.pop_front();
    checks++;
    if (m_rvalid !== (2'b01 << id)) begin
      failures++;
      $display("FAIL rr_drain: got %b, required %b", m_rvalid, 2'b01 << id);
    end
    @(negedge clk);
    s_rvalid = 1'b0;
  endtask

  task automatic test_fixed_prio();
    int id;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      fp_m_req = (i < 4) ? 2'b11 : 2'b01;
      fp_s_gnt = 1'b1;
      fp_s_rvalid = (fp_q.size() != 0);
      #1;
      checks++;
      if (fp_m_gnt !== ((i < 4) ? 2'b10 : 2'b01)) begin
        failures++;
        $display("FAIL fp_grant%0d: got %b, required %b", i, fp_m_gnt, (i < 4) ? 2'b10 : 2'b01);
      end
      if (fp_s_rvalid) begin
        id = fp_q.pop_front();
        checks++;
        if (fp_m_rvalid !== (2'b01 << id)) begin
          failures++;
          $display("FAIL fp_resp%0d: got %b, required %b", i, fp_m_rvalid, 2'b01 << id);
        end
      end
      fp_q.push_back((i < 4) ? 1 : 0);
    end
    @(negedge clk);
    fp_m_req = 2'b00; fp_s_gnt = 1'b0; fp_s_rvalid = 1'b1;
    @(negedge clk);
    fp_s_rvalid = 1'b0;
    #1;
    checks++;
    if (fp_outstanding !== 2'd0 || fp_proto_err !== 1'b0) begin
      failures++;
      $display("FAIL fp_drained: outstanding=%0d err=%b, required 0/0", fp_outstanding, fp_proto_err);
    end
  endtask

  task automatic test_full_stall();
    int id;
    apply_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      m_req = 2'b11; s_gnt = 1'b1;
      #1;
      if (m_gnt == 2'b01) exp_q.push_back(0);
      else if (m_gnt == 2'b10) exp_q.push_back(1);
    end
    @(negedge clk);
    #1;
    checks++;
    if (s_req !== 1'b0 || m_gnt !== 2'b00 || outstanding !== 2'd2) begin
      failures++;
      $display("FAIL full_stall: req=%b gnt=%b outst=%0d, required 0/00/2", s_req, m_gnt, outstanding);
    end
    @(negedge clk);
    s_rvalid = 1'b1;
    #1;
    checks++;
    if (exp_q.size() != 2 || s_req !== 1'b0 || m_rvalid !== (2'b01 << exp_q[0]) || exp_q[0] != 0) begin
      failures++;
      $display("FAIL full_pop: req=%b rvalid=%b queued=%0d, required 0/01/2", s_req, m_rvalid, exp_q.size());
    end
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    @(negedge clk);
    s_rvalid = 1'b0;
    #1;
    checks++;
    if (s_req !== 1'b1 || outstanding !== 2'd1 || m_gnt !== 2'b01) begin
      failures++;
      $display("FAIL full_resume: req=%b outst=%0d gnt=%b, required 1/1/01", s_req, outstanding, m_gnt);
    end
    exp_q.push_back(0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      m_req = 2'b00; s_gnt = 1'b0; s_rvalid = 1'b1;
      #1;
      id = exp_q.pop_front();
      checks++;
      if (m_rvalid !== (2'b01 << id)) begin
        failures++;
        $display("FAIL full_drain%0d: got %b, required %b", i, m_rvalid, 2'b01 << id);
      end
    end
    @(negedge clk);
    s_rvalid = 1'b0;
  endtask

  task automatic test_push_pop();
    int id;
    apply_reset();
    @(negedge clk);
    m_req = 2'b01; s_gnt = 1'b1;
    #1;
    if (m_gnt == 2'b01) exp_q.push_back(0);
    @(negedge clk);
    m_req = 2'b10; s_rvalid = 1'b1;
    #1;
    checks++;
    if (m_gnt !== 2'b10 || exp_q.size() != 1 || m_rvalid !== (2'b01 << exp_q[0])) begin
      failures++;
      $display("FAIL pp_both: gnt=%b rvalid=%b, required 10/01", m_gnt, m_rvalid);
    end
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    exp_q.push_back(1);
    @(negedge clk);
    m_req = 2'b00; s_gnt = 1'b0;
    #1;
    checks++;
    if (outstanding !== 2'd1) begin
      failures++;
      $display("FAIL pp_level: got %0d, required 1", outstanding);
    end
    id = exp_q.pop_front();
    checks++;
    if (m_rvalid !== (2'b01 << id)) begin
      failures++;
      $display("FAIL pp_order: got %b, required %b", m_rvalid, 2'b01 << id);
    end
    @(negedge clk);
    s_rvalid = 1'b0;
  endtask

  task automatic test_spurious();
    apply_reset();
    @(negedge clk);
    s_rvalid = 1'b1;
    #1;
    checks++;
    if (m_rvalid !== 2'b00 || proto_err !== 1'b0) begin
      failures++;
      $display("FAIL spur_resp: rvalid=%b err=%b, required 00/0", m_rvalid, proto_err);
    end
    @(negedge clk);
    s_rvalid = 1'b0;
    m_req = 2'b01; s_gnt = 1'b1;
    #1;
    checks++;
    if (proto_err !== 1'b1) begin
      failures++;
      $display("FAIL spur_err: got %b, required 1", proto_err);
    end
    @(negedge clk);
    m_req = 2'b00; s_gnt = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (proto_err !== 1'b1 || outstanding !== 2'd1) begin
      failures++;
      $display("FAIL spur_held: err=%b outst=%0d, required 1/1", proto_err, outstanding);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (proto_err !== 1'b0 || outstanding !== 2'd0) begin
      failures++;
      $display("FAIL async_rst: err=%b outst=%0d, required 0/0", proto_err, outstanding);
    end
    #1 rst = 1'b0;
    @(negedge clk);
    s_rvalid = 1'b1;
    #1;
    checks++;
    if (m_rvalid !== 2'b00) begin
      failures++;
      $display("FAIL stale_resp: got %b, required 00", m_rvalid);
    end
    @(negedge clk);
    s_rvalid = 1'b0;
    #1;
    checks++;
    if (proto_err !== 1'b1) begin
      failures++;
      $display("FAIL stale_err: got %b, required 1", proto_err);
    end
  endtask

  initial begin
    test_reset();
    test_core_read();
    test_rr_contention();
    test_fixed_prio();
    test_full_stall();
    test_push_pop();
    test_spurious();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
